// File: rtl/intc.sv
// Eight-input interrupt controller: per-source pending/mask/mode registers,
// fixed-priority vector readback (bit 0 highest) and a registered CPU request.
module intc #(
  parameter int NSRC = 8
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [1:0]      AD,
  input  logic [7:0]      DI,
  output logic [7:0]      DO,
  input  logic            RW,
  input  logic            CS,
  input  logic [NSRC-1:0] IRQ_IN,
  output logic            INTR
);

  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] mode;
  logic [NSRC-1:0] in_q;
  logic [NSRC-1:0] pend_nxt;
  logic [NSRC-1:0] active;
  logic [NSRC-1:0] edge_set;
  logic [NSRC-1:0] sw_set;
  logic [NSRC-1:0] sw_clr;

  logic            wr;
  logic            wr_pend;
  logic            wr_mask;
  logic            wr_mode;
  logic            wr_vec;
  logic            act;
  logic [2:0]      idx;
  logic [7:0]      pend_rd;
  logic [7:0]      mask_rd;
  logic [7:0]      mode_rd;

  assign wr      = CS & ~RW;
  assign wr_pend = wr && (AD == 2'd0);
  assign wr_mask = wr && (AD == 2'd1);
  assign wr_mode = wr && (AD == 2'd2);
  assign wr_vec  = wr && (AD == 2'd3);

  assign active = pend & mask;
  assign act    = |active;

  // Scan from the top down so the lowest active index wins.
  always_comb begin
    idx = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (active[i]) idx = 3'(i);
    end
  end

  // Edge-mode bits: a new edge or a software set beats a same-cycle W1C.
  always_comb begin
    edge_set = IRQ_IN & ~in_q;
    sw_set   = wr_vec  ? DI[NSRC-1:0] : '0;
    sw_clr   = wr_pend ? DI[NSRC-1:0] : '0;
    pend_nxt = (mode & (edge_set | sw_set | (pend & ~sw_clr))) | (~mode & IRQ_IN);
  end

  always_comb begin
    pend_rd = '0;
    mask_rd = '0;
    mode_rd = '0;
    pend_rd[NSRC-1:0] = pend;
    mask_rd[NSRC-1:0] = mask;
    mode_rd[NSRC-1:0] = mode;
    case (AD)
      2'd0:    DO = pend_rd;
      2'd1:    DO = mask_rd;
      2'd2:    DO = mode_rd;
      default: DO = {act, 4'b0000, idx};
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend <= '0;
      mask <= '0;
      mode <= '0;
      in_q <= '0;
      INTR <= 1'b0;
    end else begin
      pend <= pend_nxt;
      in_q <= IRQ_IN;
      INTR <= act;
      if (wr_mask) mask <= DI[NSRC-1:0];
      if (wr_mode) mode <= DI[NSRC-1:0];
    end
  end

endmodule

// File: tb/tb_intc.sv
// Bench for intc: directed scenarios plus random bus/source traffic, all
// checked against a bit-level behavioural model of the register map.
module tb_intc;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [1:0] AD = 2'd0;
  logic [7:0] DI = 8'h00;
  logic [7:0] DO;
  logic       RW = 1'b1;
  logic       CS = 1'b0;
  logic [7:0] IRQ_IN = 8'h00;
  logic       INTR;

  intc #(.NSRC(8)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .AD     (AD),
    .DI     (DI),
    .DO     (DO),
    .RW     (RW),
    .CS     (CS),
    .IRQ_IN (IRQ_IN),
    .INTR   (INTR)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;

  bit [7:0] m_pend, m_mask, m_mode, m_inq;
  bit       m_intr;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic bit [7:0] exp_vec();
    bit [7:0] a;
    a = m_pend & m_mask;
    for (int i = 0; i < 8; i++)
      if (a[i]) return {1'b1, 4'b0000, 3'(i)};
    return 8'h00;
  endfunction

  function automatic bit [7:0] exp_do(input bit [1:0] ad);
    case (ad)
      2'd0:    return m_pend;
      2'd1:    return m_mask;
      2'd2:    return m_mode;
      default: return exp_vec();
    endcase
  endfunction

  task automatic model_edge(input bit r, input bit [1:0] ad, input bit [7:0] di,
                            input bit rw, input bit cs, input bit [7:0] irq);
    bit [7:0] np;
    bit       wr;
    if (r) begin
      m_pend = 0; m_mask = 0; m_mode = 0; m_inq = 0; m_intr = 0;
    end else begin
      wr = cs && !rw;
      for (int i = 0; i < 8; i++) begin
        if (m_mode[i])
          np[i] = (irq[i] && !m_inq[i]) || (wr && ad == 2'd3 && di[i]) ||
                  (m_pend[i] && !(wr && ad == 2'd0 && di[i]));
        else
          np[i] = irq[i];
      end
      m_intr = (m_pend & m_mask) != 8'h00;
      if (wr && ad == 2'd1) m_mask = di;
      if (wr && ad == 2'd2) m_mode = di;
      m_pend = np;
      m_inq  = irq;
    end
  endtask

  // One clock: drive, check combinational DO and INTR, clock, advance model.
  task automatic cyc(input bit r, input bit [1:0] ad, input bit [7:0] di,
                     input bit rw, input bit cs, input bit [7:0] irq);
    RESET = r; AD = ad; DI = di; RW = rw; CS = cs; IRQ_IN = irq;
    #2;
    chk("do_model", DO, exp_do(ad));
    chk("intr_model", {7'b0, INTR}, {7'b0, m_intr});
    @(posedge CLK);
    model_edge(r, ad, di, rw, cs, irq);
    #1;
  endtask

  task automatic wr_reg(input bit [1:0] ad, input bit [7:0] di, input bit [7:0] irq);
    cyc(1'b0, ad, di, 1'b0, 1'b1, irq);
  endtask

  task automatic idle(input bit [7:0] irq);
    cyc(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, irq);
  endtask

  // Peek a register with CS low; no clock edge.
  task automatic expect_reg(input string tag, input bit [1:0] ad, input bit [7:0] exp);
    AD = ad; CS = 1'b0; RW = 1'b1;
    #1;
    chk(tag, DO, exp);
  endtask

  task automatic expect_intr(input string tag, input bit exp);
    chk(tag, {7'b0, INTR}, {7'b0, exp});
  endtask

  bit       r_r, r_rw, r_cs;
  bit [1:0] r_ad;
  bit [7:0] r_di, r_irq;

  initial begin
    repeat (2) @(posedge CLK);
    model_edge(1'b1, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00);
    #1;
    RESET = 1'b0;

    expect_reg("rst_pend", 2'd0, 8'h00);
    expect_reg("rst_mask", 2'd1, 8'h00);
    expect_reg("rst_mode", 2'd2, 8'h00);
    expect_reg("rst_vec",  2'd3, 8'h00);
    expect_intr("rst_intr", 1'b0);

    // Level pulse on source 3
    wr_reg(2'd1, 8'hFF, 8'h00);
    idle(8'h08);
    expect_reg("lvl_pend_hi", 2'd0, 8'h08);
    expect_intr("lvl_intr_lo", 1'b0);
    idle(8'h00);
    expect_reg("lvl_pend_lo", 2'd0, 8'h00);
    expect_intr("lvl_intr_hi", 1'b1);
    idle(8'h00);
    expect_intr("lvl_intr_gone", 1'b0);

    // Edge source 0, held high, then W1C
    wr_reg(2'd2, 8'h01, 8'h00);
    wr_reg(2'd1, 8'h01, 8'h00);
    idle(8'h01);
    expect_reg("edge_pend", 2'd0, 8'h01);
    idle(8'h01);
    expect_intr("edge_intr", 1'b1);
    idle(8'h01);
    expect_reg("edge_hold_pend", 2'd0, 8'h01);
    expect_intr("edge_hold_intr", 1'b1);
    wr_reg(2'd0, 8'h01, 8'h01);
    expect_reg("w1c_pend", 2'd0, 8'h00);
    idle(8'h00);
    expect_intr("w1c_intr", 1'b0);

    // Masked sources 5 and 2, then priority vector
    wr_reg(2'd2, 8'hFF, 8'h00);
    wr_reg(2'd1, 8'h00, 8'h00);
    idle(8'h24);
    idle(8'h00);
    expect_reg("msk_pend", 2'd0, 8'h24);
    expect_reg("msk_vec", 2'd3, 8'h00);
    expect_intr("msk_intr", 1'b0);
    wr_reg(2'd1, 8'h20, 8'h00);
    expect_reg("vec_85", 2'd3, 8'h85);
    idle(8'h00);
    expect_intr("unmask_intr", 1'b1);
    wr_reg(2'd1, 8'h24, 8'h00);
    expect_reg("vec_82", 2'd3, 8'h82);
    wr_reg(2'd0, 8'hFF, 8'h00);
    expect_reg("clr_all", 2'd0, 8'h00);

    // Edge and W1C in the same cycle: set wins
    wr_reg(2'd2, 8'h10, 8'h00);
    wr_reg(2'd0, 8'h10, 8'h10);
    expect_reg("set_wins", 2'd0, 8'h10);
    wr_reg(2'd0, 8'h10, 8'h00);

    // Software trigger
    wr_reg(2'd2, 8'h80, 8'h00);
    wr_reg(2'd1, 8'h80, 8'h00);
    wr_reg(2'd3, 8'h80, 8'h00);
    expect_reg("sw_pend", 2'd0, 8'h80);
    idle(8'h00);
    expect_intr("sw_intr", 1'b1);
    wr_reg(2'd3, 8'h01, 8'h00);
    expect_reg("sw_level_ign", 2'd0, 8'h80);

    // Mid-operation reset with a concurrent write and source 1 held high
    idle(8'h02);
    cyc(1'b1, 2'd1, 8'hFF, 1'b0, 1'b1, 8'h02);
    expect_reg("mid_rst_pend", 2'd0, 8'h00);
    expect_reg("mid_rst_mask", 2'd1, 8'h00);
    expect_reg("mid_rst_mode", 2'd2, 8'h00);
    expect_intr("mid_rst_intr", 1'b0);
    idle(8'h02);
    expect_reg("post_rst_pend", 2'd0, 8'h02);
    idle(8'h02);
    expect_intr("post_rst_intr", 1'b0);
    wr_reg(2'd1, 8'h02, 8'h02);
    idle(8'h02);
    expect_intr("post_mask_intr", 1'b1);

    // Random traffic
    r_irq = 8'h00;
    for (int n = 0; n < 600; n++) begin
      r_r   = ($urandom_range(0, 63) == 0);
      r_ad  = 2'($urandom_range(0, 3));
      r_di  = 8'($urandom);
      r_rw  = ($urandom_range(0, 2) == 0);
      r_cs  = ($urandom_range(0, 3) != 0);
      r_irq = r_irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      cyc(r_r, r_ad, r_di, r_rw, r_cs, r_irq);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
